// File: rtl/arbitro_mux_4_pkg.sv
// Shared constants, FSM state encoding and one-hot helper for the arbitro_mux_4 block.
// Latency: none (declarations only).
// Backpressure: not applicable.
package arbitro_mux_4_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Convert a requester index into its one-hot grant vector
    function automatic logic [N_REQ-1:0] onehot2(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/arbitro_mux_4_if.sv
// Requester/consumer bundle of arbitro_mux_4: four request lines and data words in, grant/select/data out.
// Latency: none (wiring only).
// Backpressure: requesters hold req high for a whole transaction; no ready path back to the consumer.
interface arbitro_mux_4_if
    import arbitro_mux_4_pkg::*;
#(
    parameter int W = 8
);
    logic [N_REQ-1:0] req;
    logic [W-1:0]     D0;
    logic [W-1:0]     D1;
    logic [W-1:0]     D2;
    logic [W-1:0]     D3;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] S;
    logic [W-1:0]     Y;
    logic             y_valid;
    logic             busy;

    // Requester side: drives requests and data, observes the arbitration result
    modport master (
        output req, D0, D1, D2, D3,
        input  gnt, S, Y, y_valid, busy
    );

    // Arbiter side
    modport slave (
        input  req, D0, D1, D2, D3,
        output gnt, S, Y, y_valid, busy
    );

endinterface

// File: rtl/arbitro_prio_4.sv
// Rotating-priority picker: first set request bit scanning ptr, ptr+1, ... modulo 4.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module arbitro_prio_4
    import arbitro_mux_4_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    // Scan from the farthest offset down to ptr so the nearest set bit is the last one written
    always_comb begin
        logic [SEL_W-1:0] cand;
        cand = '0;
        any  = 1'b0;
        idx  = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/arbitro_mux_4.sv
// Round-robin arbiter sharing one registered 4:1 W-bit mux; ARB_PRIO_FIXA_EN selects fixed priority (index 0 highest).
// Latency: req->gnt/S 1 cycle, req->Y/y_valid 2 cycles; every release costs one dead cycle.
// Backpressure: a grant lasts while req[S] stays high, cut after MAX_HOLD cycles if another requester waits.
module arbitro_mux_4
    import arbitro_mux_4_pkg::*;
#(
    parameter int W        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    arbitro_mux_4_if.slave   bus_io
);

    // MAX_HOLD of 0 disables the timeout; the counter keeps a 1-bit minimum width
    localparam int               HC_W       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int               HOLD_LIM   = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
    localparam logic [HC_W-1:0]  HOLD_TOP   = HC_W'(HOLD_LIM);
    localparam bit               TIMEOUT_EN = (MAX_HOLD > 0);

    state_t           state_q;
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] s_q;
    logic [N_REQ-1:0] gnt_q;
    logic [HC_W-1:0]  hold_q;
    logic [W-1:0]     y_q;
    logic             y_valid_q;
    logic             busy_q;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             rel_d;
    logic [HC_W-1:0]  hold_d;
    logic [SEL_W-1:0] ptr_d;
    logic [W-1:0]     sel_dat;

    arbitro_prio_4 u_prio (
        .req (bus_io.req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Release decision: owner dropped its request, or it hit the hold limit while someone else waits
    always_comb begin
        logic own_req;
        logic others_pend;
        logic hold_sat;
        own_req     = bus_io.req[s_q];
        others_pend = |(bus_io.req & ~gnt_q);
        hold_sat    = (hold_q == HOLD_TOP);
        rel_d       = !own_req || (TIMEOUT_EN && hold_sat && others_pend);
        hold_d      = hold_sat ? hold_q : hold_q + 1'b1;
`ifdef ARB_PRIO_FIXA_EN
        // Fixed priority: the scan always starts at index 0
        ptr_d       = '0;
`else
        // Round robin: the next scan starts just past the requester being released
        ptr_d       = s_q + 1'b1;
`endif
    end

    // Shared 4:1 data mux steered by the registered select code
    always_comb begin
        sel_dat = bus_io.D0;
        case (s_q)
            2'd0:    sel_dat = bus_io.D0;
            2'd1:    sel_dat = bus_io.D1;
            2'd2:    sel_dat = bus_io.D2;
            default: sel_dat = bus_io.D3;
        endcase
    end

    // Arbitration FSM with registered grant, select, data and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            s_q       <= '0;
            gnt_q     <= '0;
            hold_q    <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_q <= GRANT;
                        gnt_q   <= onehot2(pick_idx);
                        s_q     <= pick_idx;
                        busy_q  <= 1'b1;
                        hold_q  <= '0;
                    end
                end
                GRANT: begin
                    if (rel_d) begin
                        // Y keeps its last word; S keeps its last index while idle
                        state_q   <= IDLE;
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        y_valid_q <= 1'b0;
                        ptr_q     <= ptr_d;
                    end else begin
                        y_q       <= sel_dat;
                        y_valid_q <= 1'b1;
                        hold_q    <= hold_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus_io.gnt     = gnt_q;
    assign bus_io.S       = s_q;
    assign bus_io.Y       = y_q;
    assign bus_io.y_valid = y_valid_q;
    assign bus_io.busy    = busy_q;

endmodule

// File: tb/tb_arbitro_mux_4.sv
// Scoreboard bench for arbitro_mux_4 (MAX_HOLD=4): directed phases plus random traffic against a grant-ownership model.
// Latency: expected outputs are queued per driven cycle and compared on the following falling edge.
// Backpressure: requesters follow the hold-until-released rule in directed phases; random phase toggles freely.
module tb_arbitro_mux_4;

    localparam int MH = 4;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] s;
        logic [7:0] y;
        logic       yv;
        logic       busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    arbitro_mux_4_if #(.W(8)) bus();

    arbitro_mux_4 #(.W(8), .MAX_HOLD(MH)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    exp_t       exp_q[$];
    int         errs   = 0;
    int         checks = 0;
    int         gnt_log[$];
    logic [3:0] prev_gnt = 4'b0;

    // Reference model: who owns the bus, for how many visible cycles, where the next scan starts
    int         m_owner = -1;
    int         m_held  = 0;
    int         m_rr    = 0;
    logic [1:0] m_s     = 2'd0;
    logic [7:0] m_y     = 8'd0;
    logic       m_yv    = 1'b0;
    logic [7:0] dv [4];
    bit         rand_d  = 1'b1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, expv, $time);
        end
    endtask

    function automatic int first_from(input int start, input logic [3:0] rq);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (start + k) % 4;
            if (rq[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [3:0] rq);
        exp_t e;
        int   start;
        bit   others;
        if (r) begin
            m_owner = -1; m_held = 0; m_rr = 0;
            m_s = 2'd0; m_y = 8'd0; m_yv = 1'b0;
        end else if (m_owner < 0) begin
`ifdef ARB_PRIO_FIXA_EN
            start = 0;
`else
            start = m_rr;
`endif
            m_owner = first_from(start, rq);
            if (m_owner >= 0) begin
                m_s    = 2'(m_owner);
                m_held = 1;
            end
        end else begin
            others = (rq & ~(4'b0001 << m_owner)) != 4'b0;
            if (!rq[m_owner] || (m_held >= MH && others)) begin
                m_rr    = (m_owner + 1) % 4;
                m_owner = -1;
                m_yv    = 1'b0;
            end else begin
                m_y  = dv[m_owner];
                m_yv = 1'b1;
                m_held++;
            end
        end
        e.gnt  = (m_owner < 0) ? 4'b0 : 4'(4'b0001 << m_owner);
        e.s    = m_s;
        e.y    = m_y;
        e.yv   = m_yv;
        e.busy = (m_owner >= 0);
        exp_q.push_back(e);
    endtask

    // Drive one clock's worth of inputs and queue what the DUT must show after the next rising edge
    task automatic cyc(input logic r, input logic [3:0] rq);
        @(negedge clk);
        #1;
        rst     = r;
        bus.req = rq;
        if (rand_d) begin
            for (int i = 0; i < 4; i++) dv[i] = 8'($urandom);
        end
        bus.D0 = dv[0];
        bus.D1 = dv[1];
        bus.D2 = dv[2];
        bus.D3 = dv[3];
        model_step(r, rq);
    endtask

    // Monitor: compare every registered output against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt",     int'(bus.gnt),     int'(e.gnt));
                chk("S",       int'(bus.S),       int'(e.s));
                chk("busy",    int'(bus.busy),    int'(e.busy));
                chk("y_valid", int'(bus.y_valid), int'(e.yv));
                chk("Y",       int'(bus.Y),       int'(e.y));
                if (bus.gnt != 4'b0 && prev_gnt == 4'b0) gnt_log.push_back(int'(bus.S));
                prev_gnt = bus.gnt;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        logic [3:0] rq;
        int         lowcnt [4];
        int         rr_exp [5];

        rst     = 1'b1;
        bus.req = 4'b0;
        for (int i = 0; i < 4; i++) dv[i] = 8'd0;
        bus.D0 = 8'd0; bus.D1 = 8'd0; bus.D2 = 8'd0; bus.D3 = 8'd0;

        // Reset held two cycles with every requester asking, then release
        cyc(1'b1, 4'hF);
        cyc(1'b1, 4'hF);
        repeat (3) cyc(1'b0, 4'hF);
        repeat (2) cyc(1'b0, 4'h0);

        // Single requester with a fixed word
        rand_d = 1'b0;
        dv[2]  = 8'hA5;
        repeat (5) cyc(1'b0, 4'b0100);
        repeat (3) cyc(1'b0, 4'b0000);
        rand_d = 1'b1;

        // Round robin: each owner drops on its third granted cycle and re-asks two cycles later
        cyc(1'b1, 4'h0);
        gnt_log.delete();
        rq = 4'hF;
        for (int i = 0; i < 4; i++) lowcnt[i] = 0;
        repeat (40) begin
            for (int i = 0; i < 4; i++) begin
                if (!rq[i]) begin
                    lowcnt[i]++;
                    if (lowcnt[i] >= 2) rq[i] = 1'b1;
                end
            end
            if (m_owner >= 0 && m_held >= 3) begin
                rq[m_owner]     = 1'b0;
                lowcnt[m_owner] = 0;
            end
            cyc(1'b0, rq);
        end
        cyc(1'b0, 4'h0);
`ifndef ARB_PRIO_FIXA_EN
        rr_exp = '{0, 1, 2, 3, 0};
        chk("rr_grant_count_ge5", int'(gnt_log.size() >= 5), 1);
        for (int k = 0; k < 5; k++) begin
            if (k < gnt_log.size()) chk($sformatf("rr_order[%0d]", k), gnt_log[k], rr_exp[k]);
        end
`endif
        cyc(1'b0, 4'h0);

        // Timeout: two requesters held continuously
        cyc(1'b1, 4'h0);
        repeat (24) cyc(1'b0, 4'b0011);
        repeat (2) cyc(1'b0, 4'b0000);

        // No contention: a lone requester keeps the grant past the hold limit
        repeat (20) cyc(1'b0, 4'b1000);
        repeat (2) cyc(1'b0, 4'b0000);

        // Reset while index 2 owns the bus and index 1 waits; index 1 must win next
        cyc(1'b1, 4'h0);
        repeat (3) cyc(1'b0, 4'b0100);
        cyc(1'b0, 4'b0110);
        cyc(1'b1, 4'b0110);
        gnt_log.delete();
        repeat (4) cyc(1'b0, 4'b0110);
        chk("post_reset_grant_seen", int'(gnt_log.size() > 0), 1);
        if (gnt_log.size() > 0) chk("post_reset_grant_idx", gnt_log[0], 1);
        repeat (2) cyc(1'b0, 4'b0000);

        // Random traffic with occasional resets
        rq = 4'h0;
        repeat (400) begin
            logic r;
            r = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) rq[i] = ~rq[i];
            end
            cyc(r, rq);
        end

        repeat (2) cyc(1'b0, 4'h0);
        @(negedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
